// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external universal shift register: one load cycle, then N shifts.
// Optional abort input/aborted output enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] start_data,
  input  logic             start_dir,
  input  logic [CNTW-1:0]  start_count,
  input  logic             hold,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_datain,
  input  logic [WIDTH-1:0] sr_dataout,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [CNTW-1:0] MAX_COUNT = CNTW'(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [CNTW-1:0]  count_q;
  logic [CNTW-1:0]  count_clamped;
  logic             shift_en;
  logic             abort_req;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign count_clamped = (start_count > MAX_COUNT) ? MAX_COUNT : start_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start_valid) begin
        data_q  <= start_data;
        dir_q   <= start_dir;
        count_q <= count_clamped;
      end else if (shift_en) begin
        count_q <= count_q - CNTW'(1);
      end
    end
  end

  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    sr_mode     = 2'b00;
    sr_datain   = '0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    busy        = (state != IDLE);
    done        = 1'b0;
    shift_en    = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) next_state = LOAD;
      end
      LOAD: begin
        if (abort_req) begin
          next_state = IDLE;
        end else begin
          sr_mode    = 2'b11;
          sr_datain  = data_q;
          next_state = (count_q != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // Abort wins over hold; hold freezes both the register and the count
        if (abort_req) begin
          next_state = IDLE;
        end else if (!hold) begin
          shift_en  = 1'b1;
          ser_valid = 1'b1;
          sr_mode   = dir_q ? 2'b10 : 2'b01;
          ser_out   = dir_q ? sr_dataout[0] : sr_dataout[WIDTH-1];
          if (count_q == CNTW'(1)) next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
`ifdef SHIFT_SEQ_ABORT_EN
    aborted = abort_req && (state == LOAD || state == SHIFT);
`endif
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the 8-bit universal shift register (modes 00 hold, 01 left, 10 right, 11 load).
- Accepts a word/direction/count job over a valid/ready handshake.
- Drives the register's mode/datain: one load cycle, then N shift cycles.
- Presents the outgoing bit from the register output as a serial stream.
- Pulses done at the end of the job.
- Sits between a job source (e.g. UART/SPI framer) and one shift register instance.

Parameters:
WIDTH, 8, data width of the controlled shift register.
CNTW, 4, width of shift count field; must satisfy 2**CNTW > WIDTH.

Ports:
clk  in  1  clock; all state changes on posedge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
start_valid  in  1  job request.
start_ready  out  1  controller can accept a job (high only in IDLE).
start_data  in  WIDTH  word to load.
start_dir  in  1  0 = shift left (MSB out first), 1 = shift right (LSB out first).
start_count  in  CNTW  number of shifts requested.
hold  in  1  pause shifting while high.
sr_mode  out  2  mode to shift register.
sr_datain  out  WIDTH  load data to shift register.
sr_dataout  in  WIDTH  current shift register contents.
ser_out  out  1  serial bit leaving the register this cycle.
ser_valid  out  1  ser_out is valid (a shift occurs this cycle).
busy  out  1  high in LOAD/SHIFT/DONE.
done  out  1  one-cycle pulse at job completion.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. Reset (reset=0, async) forces IDLE and clears the latched data, direction and count.
- Reset output values: start_ready=1, sr_mode=00, sr_datain=0, ser_out=0, ser_valid=0, busy=0, done=0.
- All outputs are combinational decodes of state plus registered job fields. ser_out also depends on sr_dataout.
- IDLE: start_ready=1, sr_mode=00.
  - On start_valid, latch data, dir and count, then go to LOAD.
  - count>WIDTH is clamped to WIDTH at latch time.
- LOAD (exactly 1 cycle): sr_mode=11, sr_datain=latched data. The register captures the data at the end of this cycle.
  - Next state is SHIFT if count>0, else DONE.
- SHIFT, hold=0:
  - sr_mode=01 if dir=0, 10 if dir=1.
  - ser_valid=1.
  - ser_out=sr_dataout[WIDTH-1] if dir=0, sr_dataout[0] if dir=1.
  - Remaining count decrements. The cycle that decrements 1→0 transitions to DONE.
- SHIFT, hold=1: sr_mode=00, ser_valid=0, ser_out=0, count frozen, stay in SHIFT. hold is ignored in every other state.
- DONE (1 cycle): done=1, sr_mode=00, then IDLE. start_ready is low in DONE, so back-to-back jobs are separated by at least one IDLE cycle.
- Latency: start accept → first ser_valid is 2 cycles (accept edge, LOAD cycle). The job spans count+2 busy cycles plus hold cycles.
- sr_datain is 0 outside LOAD.
- Asynchronous reset mid-job returns to IDLE immediately with all outputs at reset values. The controller does not reset the shift register; its contents are don't-care for the next job because LOAD overwrites them.

Optional Feature:
SHIFT_SEQ_ABORT_EN
- Defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in LOAD or SHIFT: that cycle drives sr_mode=00 and ser_valid=0, and next state is IDLE.
  - aborted pulses high for that one cycle; no done pulse.
  - abort has priority over hold. abort is ignored in IDLE and DONE.
- Undefined: abort/aborted ports do not exist and jobs always run to DONE.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, release → start_ready=1, busy=0, sr_mode=00, done=0.
2. Left job: data=8'hA5, dir=0, count=8, sr_dataout fed by a real register model → sr_mode 11 for 1 cycle, then 01 for 8 cycles; ser_out sequence 1,0,1,0,0,1,0,1; done one cycle after the last shift; busy for 10 cycles.
3. Right job with hold: data=8'h81, dir=1, count=3, hold=1 for 2 cycles after the first shift → ser_out 1,0,0 with ser_valid gaps; sr_mode=00 during hold; done after 7 busy cycles total.
4. Zero and clamp: count=0 → LOAD then DONE, no ser_valid. count=15 → exactly 8 shifts.
5. Request while busy: assert start_valid throughout a job → start_ready=0 in LOAD/SHIFT/DONE; the second job is accepted only in the following IDLE cycle.
6. Async reset during SHIFT (after 3 shifts) → outputs at reset values without a clock edge; the next job runs normally. With SHIFT_SEQ_ABORT_EN, abort in SHIFT → aborted=1 for one cycle, no done, IDLE next.
